// File: rtl/munoc_buffered_wormhole_router.sv
// Buffered wormhole NoC router: per-input FIFO + head/route FSM, per-output registered
// round-robin arbiter that locks an output to one input from head flit to tail flit.
module munoc_bwr_input #(
  parameter int BW_PHIT    = 32,
  parameter int BW_DEST    = 2,
  parameter int NUM_OUTPUT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_last_i,
  input  logic [BW_DEST-1:0] in_dest_i,
  input  logic [BW_PHIT-1:0] in_data_i,
  input  logic               gnt_i,
  input  logic               fwd_pop_i,
  output logic               req_o,
  output logic               empty_o,
  output logic               front_last_o,
  output logic [BW_DEST-1:0] front_dest_o,
  output logic [BW_PHIT-1:0] front_data_o,
  output logic               route_error_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic               last;
    logic [BW_DEST-1:0] dest;
    logic [BW_PHIT-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {IDLE, REQ, FWD, DROP} state_t;

  flit_t          mem_q [FIFO_DEPTH];
  flit_t          front;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q;
  logic           head_q, err_q, err_d;
  state_t         state_q, state_d;
  logic           push, pop, drop_pop, dest_ok;

  assign in_ready_o    = (cnt_q != CW'(FIFO_DEPTH));
  assign push          = in_valid_i && in_ready_o;
  assign empty_o       = (cnt_q == '0);
  assign front         = mem_q[rptr_q];
  assign front_last_o  = front.last;
  assign front_dest_o  = front.dest;
  assign front_data_o  = front.data;
  assign route_error_o = err_q;
  assign dest_ok       = ({1'b0, front.dest} < (BW_DEST+1)'(NUM_OUTPUT));
  assign pop           = fwd_pop_i || drop_pop;

  // Requests go out combinationally from IDLE so the head arbitrates the cycle it reaches the front.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    req_o    = 1'b0;
    drop_pop = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (!empty_o && head_q) begin
          if (dest_ok) begin
            req_o   = 1'b1;
            state_d = gnt_i ? FWD : REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FWD:  if (fwd_pop_i && front.last) state_d = IDLE;
      DROP: begin
        if (!empty_o) begin
          drop_pop = 1'b1;
          if (front.last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_last_i, in_dest_i, in_data_i};
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      head_q  <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        head_q <= front.last;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

module munoc_buffered_wormhole_router #(
  parameter int BW_PHIT    = 32,
  parameter int NUM_INPUT  = 4,
  parameter int NUM_OUTPUT = 4,
  parameter int BW_DEST    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic [NUM_INPUT-1:0]          in_valid_list,
  output logic [NUM_INPUT-1:0]          in_ready_list,
  input  logic [NUM_INPUT-1:0]          in_last_list,
  input  logic [BW_DEST*NUM_INPUT-1:0]  in_dest_list,
  input  logic [BW_PHIT*NUM_INPUT-1:0]  in_data_list,
  output logic [NUM_OUTPUT-1:0]         out_valid_list,
  input  logic [NUM_OUTPUT-1:0]         out_ready_list,
  output logic [NUM_OUTPUT-1:0]         out_last_list,
  output logic [BW_PHIT*NUM_OUTPUT-1:0] out_data_list,
  output logic [NUM_INPUT-1:0]          route_error_list
);
  localparam int IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;

  logic [NUM_INPUT-1:0]                 req, empty, flast, gnt, fwd_pop;
  logic [NUM_INPUT-1:0][BW_DEST-1:0]    fdest;
  logic [NUM_INPUT-1:0][BW_PHIT-1:0]    fdata;
  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] gnt_oh;
  logic [NUM_OUTPUT-1:0][IW-1:0]        owner;
  logic [NUM_OUTPUT-1:0]                xfer;

  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_in
    munoc_bwr_input #(
      .BW_PHIT(BW_PHIT), .BW_DEST(BW_DEST), .NUM_OUTPUT(NUM_OUTPUT), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_in (
      .clk           (clk),
      .rstnn         (rstnn),
      .in_valid_i    (in_valid_list[i]),
      .in_ready_o    (in_ready_list[i]),
      .in_last_i     (in_last_list[i]),
      .in_dest_i     (in_dest_list[i*BW_DEST +: BW_DEST]),
      .in_data_i     (in_data_list[i*BW_PHIT +: BW_PHIT]),
      .gnt_i         (gnt[i]),
      .fwd_pop_i     (fwd_pop[i]),
      .req_o         (req[i]),
      .empty_o       (empty[i]),
      .front_last_o  (flast[i]),
      .front_dest_o  (fdest[i]),
      .front_data_o  (fdata[i]),
      .route_error_o (route_error_list[i])
    );
  end

  for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_out
    logic                 lock_q, found;
    logic [IW-1:0]        owner_q, ptr_q, widx;
    logic [NUM_INPUT-1:0] oreq, oh;

    // Search starts at the pointer; the lock suppresses arbitration until the tail leaves.
    always_comb begin
      oreq  = '0;
      oh    = '0;
      found = 1'b0;
      widx  = '0;
      for (int i = 0; i < NUM_INPUT; i++) oreq[i] = req[i] && (fdest[i] == BW_DEST'(o));
      for (int k = 0; k < NUM_INPUT; k++) begin
        if (!found && oreq[IW'((int'(ptr_q) + k) % NUM_INPUT)]) begin
          found = 1'b1;
          widx  = IW'((int'(ptr_q) + k) % NUM_INPUT);
        end
      end
      if (!lock_q && found) oh[widx] = 1'b1;
    end

    assign gnt_oh[o]                            = oh;
    assign owner[o]                             = owner_q;
    assign out_valid_list[o]                    = lock_q && !empty[owner_q];
    assign out_last_list[o]                     = flast[owner_q];
    assign out_data_list[o*BW_PHIT +: BW_PHIT]  = fdata[owner_q];
    assign xfer[o]                              = out_valid_list[o] && out_ready_list[o];

    always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
        lock_q  <= 1'b0;
        owner_q <= '0;
        ptr_q   <= '0;
      end else if (lock_q) begin
        if (xfer[o] && flast[owner_q]) lock_q <= 1'b0;
      end else if (found) begin
        lock_q  <= 1'b1;
        owner_q <= widx;
        ptr_q   <= (widx == IW'(NUM_INPUT-1)) ? '0 : widx + 1'b1;
      end
    end
  end

  always_comb begin
    gnt     = '0;
    fwd_pop = '0;
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      gnt = gnt | gnt_oh[o];
      for (int i = 0; i < NUM_INPUT; i++)
        if (xfer[o] && owner[o] == IW'(i)) fwd_pop[i] = 1'b1;
    end
  end
endmodule

// File: tb/tb_munoc_buffered_wormhole_router.sv
// Directed bench for the buffered wormhole router: a 4x4 instance plus a 4x3 instance
// used to exercise out-of-range destinations.
module tb_munoc_buffered_wormhole_router;
  logic         clk = 1'b0;
  logic         rstnn = 1'b0;
  logic [3:0]   in_valid, in_ready, in_last, out_valid, out_ready, out_last, rerr;
  logic [7:0]   in_dest;
  logic [127:0] in_data, out_data;
  logic [3:0]   v3, r3, l3, rerr3;
  logic [7:0]   d3;
  logic [127:0] dat3;
  logic [2:0]   ov3, ordy3, ol3;
  logic [95:0]  od3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  munoc_buffered_wormhole_router dut (
    .clk(clk), .rstnn(rstnn),
    .in_valid_list(in_valid), .in_ready_list(in_ready), .in_last_list(in_last),
    .in_dest_list(in_dest), .in_data_list(in_data),
    .out_valid_list(out_valid), .out_ready_list(out_ready), .out_last_list(out_last),
    .out_data_list(out_data), .route_error_list(rerr)
  );

  munoc_buffered_wormhole_router #(.NUM_OUTPUT(3)) dut3 (
    .clk(clk), .rstnn(rstnn),
    .in_valid_list(v3), .in_ready_list(r3), .in_last_list(l3),
    .in_dest_list(d3), .in_data_list(dat3),
    .out_valid_list(ov3), .out_ready_list(ordy3), .out_last_list(ol3),
    .out_data_list(od3), .route_error_list(rerr3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic last,
                       input logic [1:0] dest, input logic [31:0] data);
    in_valid[i]          = v;
    in_last[i]           = last;
    in_dest[i*2 +: 2]    = dest;
    in_data[i*32 +: 32]  = data;
  endtask

  task automatic drive3(input int i, input logic v, input logic last,
                        input logic [1:0] dest, input logic [31:0] data);
    v3[i]             = v;
    l3[i]             = last;
    d3[i*2 +: 2]      = dest;
    dat3[i*32 +: 32]  = data;
  endtask

  task automatic idle_all();
    in_valid = '0; in_last = '0; in_dest = '0; in_data = '0;
    v3 = '0; l3 = '0; d3 = '0; dat3 = '0;
  endtask

  task automatic do_reset();
    rstnn = 1'b0;
    idle_all();
    out_ready = '1;
    ordy3 = '1;
    step();
    step();
    rstnn = 1'b1;
  endtask

  function automatic logic [31:0] od(input int o);
    return out_data[o*32 +: 32];
  endfunction

  initial begin
    int src2 [14] = '{-1, -1, 0, 0, 0, -1, 1, 1, 1, -1, 3, 3, 3, -1};
    int k2   [14] = '{ 0,  0, 0, 1, 2,  0, 0, 1, 2,  0, 0, 1, 2,  0};
    int srcs [3]  = '{0, 1, 3};
    int sent, rcv;

    do_reset();
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_route_err", rerr, 4'h0);
    check("rst3_out_valid", ov3, 3'h0);
    check("rst3_route_err", rerr3, 4'h0);

    // single flit, latency 2
    drive(0, 1'b1, 1'b1, 2'd2, 32'hA5);
    step();
    idle_all();
    check("t1_c1_valid", out_valid, 4'h0);
    step();
    check("t1_c2_valid", out_valid, 4'b0100);
    check("t1_c2_data", od(2), 32'hA5);
    check("t1_c2_last", out_last[2], 1'b1);
    step();
    check("t1_c3_valid", out_valid, 4'h0);

    // three contending packets on out1, two rounds
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 14; c++) begin
        for (int s = 0; s < 3; s++) begin
          if (c < 3) drive(srcs[s], 1'b1, c == 2, 2'd1, 32'(r*32'h1000 + srcs[s]*32'h100 + c));
          else       drive(srcs[s], 1'b0, 1'b0, 2'd0, 32'h0);
        end
        check("t2_valid", out_valid[1], src2[c] >= 0);
        check("t2_others", out_valid & 4'b1101, 4'h0);
        if (src2[c] >= 0) begin
          check("t2_data", od(1), 32'(r*32'h1000 + src2[c]*32'h100 + k2[c]));
          check("t2_last", out_last[1], k2[c] == 2);
        end
        step();
      end
    end

    // backpressure: out0 stalled 12 cycles, in2 streams 8 flits
    do_reset();
    sent = 0;
    rcv = 0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      out_ready[0] = (c >= 12);
      drive(2, sent < 8, sent == 7, 2'd0, 32'(32'h300 + sent));
      if (c == 4) begin
        check("t3_accepted", sent, 4);
        check("t3_ready_low", in_ready[2], 1'b0);
      end
      if (c == 11) begin
        check("t3_hold_valid", out_valid[0], 1'b1);
        check("t3_hold_data", od(0), 32'h300);
        check("t3_ready_still_low", in_ready[2], 1'b0);
      end
      if (out_valid[0] && out_ready[0]) begin
        check("t3_data", od(0), 32'(32'h300 + rcv));
        check("t3_last", out_last[0], rcv == 7);
        rcv++;
      end
      if (in_valid[2] && in_ready[2]) sent++;
      step();
    end
    idle_all();
    check("t3_received", rcv, 8);
    check("t3_sent", sent, 8);
    check("t3_no_dup", out_valid[0], 1'b0);

    // two disjoint paths concurrently
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        drive(0, 1'b1, c == 3, 2'd3, 32'(32'h400 + c));
        drive(3, 1'b1, c == 3, 2'd0, 32'(32'h430 + c));
      end else begin
        idle_all();
      end
      check("t4_v3", out_valid[3], c >= 2 && c <= 5);
      check("t4_v0", out_valid[0], c >= 2 && c <= 5);
      if (c >= 2 && c <= 5) begin
        check("t4_d3", od(3), 32'(32'h400 + c - 2));
        check("t4_d0", od(0), 32'(32'h430 + c - 2));
        check("t4_l3", out_last[3], c == 5);
      end
      step();
    end

    // out-of-range destination on the 3-output instance
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 3)      drive3(1, 1'b1, c == 2, 2'd3, 32'(32'h500 + c));
      else if (c < 5) drive3(1, 1'b1, c == 4, 2'd0, 32'(32'h510 + c - 3));
      else            drive3(1, 1'b0, 1'b0, 2'd0, 32'h0);
      check("t5_route_err", rerr3, (c >= 2) ? 4'b0010 : 4'b0000);
      check("t5_valid", ov3, (c == 6 || c == 7) ? 3'b001 : 3'b000);
      if (c == 6 || c == 7) begin
        check("t5_data", od3[31:0], 32'(32'h510 + c - 6));
        check("t5_last", ol3[0], c == 7);
      end
      step();
    end

    // mid-packet reset, then a fresh packet
    for (int c = 0; c < 4; c++) begin
      drive(2, 1'b1, c == 3, 2'd1, 32'(32'h600 + c));
      if (c >= 2) check("t6_pre_data", od(1), 32'(32'h600 + c - 2));
      if (c < 3) step();
    end
    rstnn = 1'b0;
    idle_all();
    #2;
    check("t6_rst_valid", out_valid, 4'h0);
    check("t6_rst_ready", in_ready, 4'hF);
    check("t6_rst_err3", rerr3, 4'h0);
    check("t6_rst_valid3", ov3, 3'h0);
    step();
    step();
    rstnn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(2, 1'b1, c == 1, 2'd1, 32'(32'h700 + c));
      else       idle_all();
      check("t6_valid", out_valid, (c == 2 || c == 3) ? 4'b0010 : 4'b0000);
      if (c == 2 || c == 3) begin
        check("t6_data", od(1), 32'(32'h700 + c - 2));
        check("t6_last", out_last[1], c == 3);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
